// File: rtl/index_bitmap_pkg.sv
// Shared definitions for the entry-pool occupancy bitmap: width helpers and
// the priority-direction selectors used by the free-entry encoder.
package index_bitmap_pkg;

    // Priority direction selectors for the free-entry encoder.
    localparam string LSB_PRIORITY_LOW  = "LOW";
    localparam string LSB_PRIORITY_HIGH = "HIGH";

    // Width of an encoded entry index (at least one bit).
    function automatic int idx_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Width needed to hold a live-entry count in 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/index_bitmap_if.sv
// Request/response bundle between the CAM write/delete control path (master)
// and the occupancy bitmap (slave).
interface index_bitmap_if #(
    parameter int WIDTH = 4
);
    import index_bitmap_pkg::*;

    localparam int IW = idx_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    // Requests
    logic          set_valid;
    logic [IW-1:0] set_index;
    logic          clr_valid;
    logic [IW-1:0] clr_index;
    logic          alloc_req;
    logic          flush;

    // Registered state and responses
    logic [WIDTH-1:0] bitmap;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             alloc_ack;
    logic             alloc_ok;
    logic [IW-1:0]    alloc_index;
    logic             err;

    modport master (
        output set_valid, set_index, clr_valid, clr_index, alloc_req, flush,
        input  bitmap, count, full, empty, alloc_ack, alloc_ok, alloc_index, err
    );

    modport slave (
        input  set_valid, set_index, clr_valid, clr_index, alloc_req, flush,
        output bitmap, count, full, empty, alloc_ack, alloc_ok, alloc_index, err
    );

endinterface

// File: rtl/index_bitmap_priority_encoder.sv
// Picks one asserted request bit and returns its encoded index. "LOW" gives
// the lowest asserted bit, anything else the highest.
module index_bitmap_priority_encoder
    import index_bitmap_pkg::*;
#(
    parameter int    WIDTH        = 4,
    parameter string LSB_PRIORITY = "LOW",
    localparam int   IW           = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic [IW-1:0]    index,
    output logic             found
);

    assign found = |req;

    if (LSB_PRIORITY == LSB_PRIORITY_LOW) begin : g_low
        // Scan downward so the lowest asserted bit is the last to overwrite.
        always_comb begin
            index = '0;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    index = IW'(i);
                end
            end
        end
    end else begin : g_high
        // Scan upward so the highest asserted bit is the last to overwrite.
        always_comb begin
            index = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (req[i]) begin
                    index = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/index_bitmap.sv
// Registered occupancy bitmap for the CAM entry pool. Decodes set/clear
// indices to one-hot masks, allocates the lowest free entry in one cycle,
// and keeps an incrementally maintained live count with full/empty flags.
module index_bitmap
    import index_bitmap_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    index_bitmap_if.slave bus
);

    localparam int IW = idx_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] bitmap_reg, bitmap_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             full_reg, full_next;
    logic             empty_reg, empty_next;
    logic             alloc_ack_reg, alloc_ack_next;
    logic             alloc_ok_reg, alloc_ok_next;
    logic [IW-1:0]    alloc_index_reg, alloc_index_next;
    logic             err_reg, err_next;

    logic [WIDTH-1:0] set_m, clr_m, free_v, alloc_m;
    logic             set_oor, clr_oor;
    logic [IW-1:0]    pe_index;
    logic             pe_found;
    logic             alloc_take;
    logic             set_new, clr_eff;

    // Indices beyond the last entry only exist when WIDTH is not a power of two.
    if ((1 << IW) != WIDTH) begin : g_range
        assign set_oor = bus.set_valid && (int'(bus.set_index) >= WIDTH);
        assign clr_oor = bus.clr_valid && (int'(bus.clr_index) >= WIDTH);
    end else begin : g_no_range
        assign set_oor = 1'b0;
        assign clr_oor = 1'b0;
    end

    // One-hot decode of the set and clear indices; out-of-range gives no bit.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mask
        assign set_m[gi] = bus.set_valid && !set_oor && (bus.set_index == IW'(gi));
        assign clr_m[gi] = bus.clr_valid && !clr_oor && (bus.clr_index == IW'(gi));
    end

    // Entries being cleared stay busy this cycle; entries being set are taken.
    assign free_v = ~bitmap_reg & ~set_m;

    index_bitmap_priority_encoder #(
        .WIDTH       (WIDTH),
        .LSB_PRIORITY(LSB_PRIORITY_LOW)
    ) u_alloc_pe (
        .req  (free_v),
        .index(pe_index),
        .found(pe_found)
    );

    assign alloc_take = bus.alloc_req && pe_found && !bus.flush;
    assign alloc_m    = alloc_take ? (WIDTH'(1) << pe_index) : '0;

    // Count deltas: a set only counts on a previously empty entry, and a clear
    // only counts on a busy entry that is not re-set in the same cycle.
    assign set_new = |(set_m & ~bitmap_reg);
    assign clr_eff = |(clr_m & bitmap_reg & ~set_m);

    // Next-state for bitmap, count, flags and the allocation response.
    always_comb begin
        bitmap_next      = bitmap_reg;
        count_next       = count_reg;
        err_next         = 1'b0;
        alloc_ack_next   = bus.alloc_req;
        alloc_ok_next    = 1'b0;
        alloc_index_next = '0;

        if (bus.flush) begin
            bitmap_next = '0;
            count_next  = '0;
        end else begin
            bitmap_next      = (bitmap_reg & ~clr_m) | set_m | alloc_m;
            count_next       = count_reg + CW'(set_new) + CW'(alloc_take) - CW'(clr_eff);
            err_next         = set_oor || clr_oor
                             || (|(set_m & bitmap_reg & ~clr_m))
                             || (|(clr_m & ~bitmap_reg & ~set_m));
            alloc_ok_next    = alloc_take;
            alloc_index_next = alloc_take ? pe_index : '0;
        end

        full_next  = (count_next == CW'(WIDTH));
        empty_next = (count_next == '0);
    end

    // State and response registers; reset discards any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitmap_reg      <= '0;
            count_reg       <= '0;
            full_reg        <= 1'b0;
            empty_reg       <= 1'b1;
            alloc_ack_reg   <= 1'b0;
            alloc_ok_reg    <= 1'b0;
            alloc_index_reg <= '0;
            err_reg         <= 1'b0;
        end else begin
            bitmap_reg      <= bitmap_next;
            count_reg       <= count_next;
            full_reg        <= full_next;
            empty_reg       <= empty_next;
            alloc_ack_reg   <= alloc_ack_next;
            alloc_ok_reg    <= alloc_ok_next;
            alloc_index_reg <= alloc_index_next;
            err_reg         <= err_next;
        end
    end

    assign bus.bitmap      = bitmap_reg;
    assign bus.count       = count_reg;
    assign bus.full        = full_reg;
    assign bus.empty       = empty_reg;
    assign bus.alloc_ack   = alloc_ack_reg;
    assign bus.alloc_ok    = alloc_ok_reg;
    assign bus.alloc_index = alloc_index_reg;
    assign bus.err         = err_reg;

endmodule
